// File: rtl/sram_sp_arbiter.sv
// sram_sp_arbiter: two requesters sharing one single-port synchronous SRAM.
// Each access takes ACCESS (SRAM strobe) then RESP (ack, read data from SRAM).
// Optional feature: define SRAM_SP_ARB_RR_EN for round-robin arbitration;
// otherwise port 0 has fixed priority.
module sram_sp_arbiter #(
  parameter int PLEN    = 32,
  parameter int XLEN    = 32,
  parameter int WORD_AW = PLEN - ((XLEN / 8) >> 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [WORD_AW-1:0]    addr0,
  input  logic [XLEN-1:0]       wdata0,
  input  logic [(XLEN/8)-1:0]   sel0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [WORD_AW-1:0]    addr1,
  input  logic [XLEN-1:0]       wdata1,
  input  logic [(XLEN/8)-1:0]   sel1,
  output logic                  ack1,
  output logic [XLEN-1:0]       rdata,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [WORD_AW-1:0]    mem_waddr,
  output logic [XLEN-1:0]       mem_din,
  output logic [(XLEN/8)-1:0]   mem_sel,
  input  logic [XLEN-1:0]       mem_dout
);

  localparam int SW = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_owner;
  logic                 r_we;
  logic [WORD_AW-1:0]   r_waddr;
  logic [XLEN-1:0]      r_din;
  logic [SW-1:0]        r_sel;
  logic [1:0]           w_elig;
  logic                 w_grant;
  logic                 w_win;

`ifdef SRAM_SP_ARB_RR_EN
  logic                 r_ptr;

  // Favour the port that did not receive the most recent grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_grant) begin
      r_ptr <= ~w_win;
    end
  end
`endif

  // Eligible requesters; the owner being acked in RESP may still hold req
  always_comb begin
    w_elig = {req1, req0};
    if (r_state == RESP) begin
      w_elig[r_owner] = 1'b0;
    end
  end

  // Pick a winner whenever the SRAM is free for a new access next cycle
  always_comb begin
    w_grant = 1'b0;
    w_win   = 1'b0;
    if (r_state != ACCESS) begin
      w_grant = |w_elig;
`ifdef SRAM_SP_ARB_RR_EN
      if (&w_elig) begin
        w_win = r_ptr;
      end else begin
        w_win = w_elig[1];
      end
`else
      w_win = ~w_elig[0];
`endif
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = w_grant ? ACCESS : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the winner's request; SRAM address/data/select hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_din   <= '0;
      r_sel   <= '0;
    end else if (w_grant) begin
      r_owner <= w_win;
      r_we    <= w_win ? we1    : we0;
      r_waddr <= w_win ? addr1  : addr0;
      r_din   <= w_win ? wdata1 : wdata0;
      r_sel   <= w_win ? sel1   : sel0;
    end
  end

  // SRAM strobes in ACCESS, completion pulse to the owner in RESP
  always_comb begin
    mem_ce = 1'b0;
    mem_we = 1'b0;
    mem_oe = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    if (r_state == ACCESS) begin
      mem_ce = 1'b1;
      mem_we = r_we;
      mem_oe = ~r_we;
    end
    if (r_state == RESP) begin
      ack0 = ~r_owner;
      ack1 = r_owner;
    end
  end

  assign mem_waddr = r_waddr;
  assign mem_din   = r_din;
  assign mem_sel   = r_sel;
  assign rdata     = mem_dout;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// tb_sram_sp_arbiter: randomized two-requester traffic against a cycle-number
// scheduling model (each grant occupies the SRAM for two cycles) plus a
// byte-merging memory model for read data.
module tb_sram_sp_arbiter;

  localparam int PLEN    = 32;
  localparam int XLEN    = 32;
  localparam int SW      = XLEN / 8;
  localparam int WORD_AW = PLEN - (SW >> 1);

  logic                clk = 1'b0;
  logic                rst;
  logic                req0, we0, ack0, req1, we1, ack1;
  logic [WORD_AW-1:0]  addr0, addr1, mem_waddr;
  logic [XLEN-1:0]     wdata0, wdata1, rdata, mem_din, mem_dout;
  logic [SW-1:0]       sel0, sel1, mem_sel;
  logic                mem_ce, mem_we, mem_oe;

  always #5 clk = ~clk;

  sram_sp_arbiter #(.PLEN(PLEN), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .sel0(sel0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .sel1(sel1), .ack1(ack1),
    .rdata(rdata), .mem_ce(mem_ce), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_sel(mem_sel), .mem_dout(mem_dout)
  );

  // Reference memory (updated at transaction level) and SRAM image
  logic [XLEN-1:0] ref_mem [16];
  logic [XLEN-1:0] sram    [16];
  logic            load_mem;

  // Synchronous SRAM: byte-masked write, one-cycle registered read
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) sram[i] <= ref_mem[i];
    end else if (mem_ce) begin
      if (mem_we) begin
        for (int b = 0; b < SW; b++)
          if (mem_sel[b]) sram[mem_waddr[3:0]][8*b +: 8] <= mem_din[8*b +: 8];
      end else if (mem_oe) begin
        mem_dout <= sram[mem_waddr[3:0]];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] wd,
                                            input logic [SW-1:0]   s);
    merge = old;
    for (int b = 0; b < SW; b++)
      if (s[b]) merge[8*b +: 8] = wd[8*b +: 8];
  endfunction

  // Requester and scheduling model state
  logic               pend [2];
  logic               t_we [2];
  logic [WORD_AW-1:0] t_addr [2];
  logic [XLEN-1:0]    t_wd [2];
  logic [SW-1:0]      t_sel [2];
  int                 exp_ack [2];
  int                 last_ack [2];
  logic               just_acked [2];
  int                 busy_until;
  logic               rr_ptr;
  logic               rst_req, post_rst;

  task automatic apply();
    req0 = pend[0]; we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wd[0]; sel0 = t_sel[0];
    req1 = pend[1]; we1 = t_we[1]; addr1 = t_addr[1]; wdata1 = t_wd[1]; sel1 = t_sel[1];
  endtask

  task automatic issue(input int p, input logic we, input logic [WORD_AW-1:0] a,
                       input logic [XLEN-1:0] wd, input logic [SW-1:0] s);
    pend[p] = 1'b1; t_we[p] = we; t_addr[p] = a; t_wd[p] = wd; t_sel[p] = s;
    apply();
  endtask

  task automatic step(input int unsigned pct);
    logic [1:0] elig;
    int w;
    int acc;
    // Grant taken at the coming edge: SRAM free if nothing is in flight or
    // the in-flight access completes in this cycle
    if (!rst && busy_until <= cyc) begin
      elig = 2'b00;
      for (int p = 0; p < 2; p++) elig[p] = pend[p] && (exp_ack[p] < 0) && !just_acked[p];
      w = -1;
      if (elig == 2'b11) begin
`ifdef SRAM_SP_ARB_RR_EN
        w = rr_ptr ? 1 : 0;
`else
        w = 0;
`endif
      end else if (elig[0]) w = 0;
      else if (elig[1]) w = 1;
      if (w >= 0) begin
        exp_ack[w] = cyc + 2;
        busy_until = cyc + 2;
        rr_ptr     = (w == 0);
      end
    end

    @(negedge clk);
    cyc++;
    just_acked[0] = 1'b0;
    just_acked[1] = 1'b0;

    acc = -1;
    for (int p = 0; p < 2; p++) if (exp_ack[p] == cyc + 1) acc = p;

    chk("ack0", 64'(ack0), 64'(exp_ack[0] == cyc));
    chk("ack1", 64'(ack1), 64'(exp_ack[1] == cyc));
    if (acc >= 0) begin
      chk("mem_ce", 64'(mem_ce), 64'(1));
      chk("mem_we", 64'(mem_we), 64'(t_we[acc]));
      chk("mem_oe", 64'(mem_oe), 64'(!t_we[acc]));
      chk("mem_waddr", 64'(mem_waddr), 64'(t_addr[acc]));
      chk("mem_din", 64'(mem_din), 64'(t_wd[acc]));
      chk("mem_sel", 64'(mem_sel), 64'(t_sel[acc]));
    end else begin
      chk("mem_ctl_idle", 64'({mem_ce, mem_we, mem_oe}), 64'(0));
    end
    if (post_rst) begin
      chk("rst_waddr", 64'(mem_waddr), 64'(0));
      chk("rst_din", 64'(mem_din), 64'(0));
      chk("rst_sel", 64'(mem_sel), 64'(0));
      rst      = 1'b0;
      post_rst = 1'b0;
    end

    for (int p = 0; p < 2; p++) begin
      if (exp_ack[p] == cyc) begin
        if (t_we[p]) ref_mem[t_addr[p][3:0]] = merge(ref_mem[t_addr[p][3:0]], t_wd[p], t_sel[p]);
        else chk("rdata", 64'(rdata), 64'(ref_mem[t_addr[p][3:0]]));
        pend[p]       = 1'b0;
        exp_ack[p]    = -1;
        just_acked[p] = 1'b1;
        last_ack[p]   = cyc;
      end
    end

    // Abort the transaction in ACCESS; its SRAM write still lands
    if (rst_req && acc >= 0) begin
      rst = 1'b1;
      if (t_we[acc]) ref_mem[t_addr[acc][3:0]] = merge(ref_mem[t_addr[acc][3:0]], t_wd[acc], t_sel[acc]);
      for (int p = 0; p < 2; p++) begin
        pend[p] = 1'b0; exp_ack[p] = -1; just_acked[p] = 1'b0;
      end
      busy_until = -1;
      rr_ptr     = 1'b0;
      rst_req    = 1'b0;
      post_rst   = 1'b1;
      apply();
      return;
    end

    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && !rst && ($urandom_range(99) < pct)) begin
        pend[p]   = 1'b1;
        t_we[p]   = 1'($urandom);
        t_addr[p] = WORD_AW'($urandom);
        t_wd[p]   = $urandom;
        t_sel[p]  = SW'($urandom);
      end
    end
    apply();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; load_mem = 1'b1; cyc = 0; busy_until = -1; rr_ptr = 1'b0;
    rst_req = 1'b0; post_rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; t_we[p] = 1'b0; t_addr[p] = '0; t_wd[p] = '0; t_sel[p] = '0;
      exp_ack[p] = -1; last_ack[p] = -1; just_acked[p] = 1'b0;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'hDEADBEEF;
    apply();
    repeat (3) @(posedge clk);
    @(negedge clk);
    load_mem = 1'b0;

    chk("reset_ack0", 64'(ack0), 64'(0));
    chk("reset_ack1", 64'(ack1), 64'(0));
    chk("reset_ctl", 64'({mem_ce, mem_we, mem_oe}), 64'(0));
    chk("reset_waddr", 64'(mem_waddr), 64'(0));
    chk("reset_din", 64'(mem_din), 64'(0));
    chk("reset_sel", 64'(mem_sel), 64'(0));
    rst = 1'b0;

    // Single read of 0xDEADBEEF at word 0x10
    issue(0, 1'b0, WORD_AW'('h10), '0, '1);
    repeat (4) step(0);

    // Port 1 partial write then read back the merged word at 0x4
    issue(1, 1'b1, WORD_AW'('h4), 32'h12345678, 4'b0011);
    repeat (4) step(0);
    issue(1, 1'b0, WORD_AW'('h4), '0, '1);
    repeat (4) step(0);

    // Simultaneous requests from IDLE: back-to-back accesses
    t0 = cyc;
    issue(0, 1'b0, WORD_AW'($urandom), $urandom, '1);
    issue(1, 1'b1, WORD_AW'($urandom), $urandom, SW'($urandom));
    repeat (6) step(0);
    chk("contend_lat0", 64'(last_ack[0] - t0), 64'(2));
    chk("contend_gap", 64'(last_ack[1] - last_ack[0]), 64'(2));

    // Random traffic: sparse, then both ports saturating
    repeat (400) step(30);
    repeat (300) step(100);

    // Reset landing in an ACCESS cycle
    rst_req = 1'b1;
    for (int i = 0; i < 40 && rst_req; i++) step(100);
    chk("rst_window", 64'(rst_req), 64'(0));
    rst_req = 1'b0;
    repeat (2) step(0);

    repeat (150) step(50);
    repeat (8) step(0);
    chk("drain0", 64'(pend[0]), 64'(0));
    chk("drain1", 64'(pend[1]), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
